// File: rtl/qam16_mapper_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qam16_mapper_if : byte-in / symbol-out stream bundle for the QAM16 mapper   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface qam16_mapper_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    // Environment side: drives bytes in, drains symbols out.
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

    // Mapper side.
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
endinterface
`default_nettype wire

// File: rtl/qam16_mapper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qam16_mapper : byte -> two Gray-coded 16-QAM symbols {Q,I}, frame m_last    |
// | Option macro : QAM16_MAPPER_SCRAMBLE_EN (x^7+x^4+1 byte scrambler)          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module qam16_mapper #(
    parameter int LVL           = 32,
    parameter int SYM_PER_FRAME = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    qam16_mapper_if.slave bus
);
    localparam int c_CNT_W = $clog2(SYM_PER_FRAME);
    localparam logic [7:0] c_P1 = 8'(LVL);
    localparam logic [7:0] c_P3 = 8'(3 * LVL);
    localparam logic [7:0] c_N1 = 8'(-LVL);
    localparam logic [7:0] c_N3 = 8'(-3 * LVL);

    logic [7:0]         r_byte;
    logic               r_full;
    logic               r_half;
    logic [15:0]        r_m_data;
    logic               r_m_valid;
    logic               r_m_last;
    logic [c_CNT_W-1:0] r_sym_cnt;

    logic       w_adv;
    logic       w_load;
    logic       w_s_ready;
    logic       w_accept;
    logic       w_last;
    logic [3:0] w_nib;
    logic [7:0] w_i;
    logic [7:0] w_q;
    logic [7:0] w_store;

    assign w_adv     = !r_m_valid || bus.m_ready;
    assign w_load    = r_full && w_adv;
    // Accepting while the low nibble loads keeps one symbol per cycle.
    assign w_s_ready = !r_full || (r_half && w_adv);
    assign w_accept  = bus.s_valid && w_s_ready;
    assign w_nib     = r_half ? r_byte[3:0] : r_byte[7:4];
    assign w_last    = (r_sym_cnt == c_CNT_W'(SYM_PER_FRAME - 1));

    always_comb begin
        w_i = c_N3;
        w_q = c_P3;
        case (w_nib[3:2])
            2'b00:   w_i = c_N3;
            2'b01:   w_i = c_N1;
            2'b11:   w_i = c_P1;
            default: w_i = c_P3;
        endcase
        case (w_nib[1:0])
            2'b10:   w_q = c_N3;
            2'b11:   w_q = c_N1;
            2'b01:   w_q = c_P1;
            default: w_q = c_P3;
        endcase
    end

`ifdef QAM16_MAPPER_SCRAMBLE_EN
    localparam int c_BYTES  = SYM_PER_FRAME / 2;
    localparam int c_BCNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

    logic [6:0]          r_lfsr;
    logic [c_BCNT_W-1:0] r_bcnt;
    logic [6:0]          w_lfsr_nxt;
    logic [7:0]          w_scr;

    always_comb begin
        logic v_fb;
        w_lfsr_nxt = r_lfsr;
        w_scr      = '0;
        v_fb       = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            v_fb       = w_lfsr_nxt[6] ^ w_lfsr_nxt[3];
            w_scr[k]   = bus.s_data[k] ^ v_fb;
            w_lfsr_nxt = {w_lfsr_nxt[5:0], v_fb};
        end
    end

    // Reseed on the last byte of a frame so the next frame starts from 7'h7F.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 7'h7F;
            r_bcnt <= '0;
        end else if (w_accept) begin
            if (r_bcnt == c_BCNT_W'(c_BYTES - 1)) begin
                r_lfsr <= 7'h7F;
                r_bcnt <= '0;
            end else begin
                r_lfsr <= w_lfsr_nxt;
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    assign w_store = w_scr;
`else
    assign w_store = bus.s_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte    <= '0;
            r_full    <= 1'b0;
            r_half    <= 1'b0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_sym_cnt <= '0;
        end else begin
            if (w_load) begin
                r_m_data  <= {w_q, w_i};
                r_m_valid <= 1'b1;
                r_m_last  <= w_last;
                r_sym_cnt <= w_last ? '0 : r_sym_cnt + 1'b1;
                if (r_half) begin
                    r_full <= 1'b0;
                    r_half <= 1'b0;
                end else begin
                    r_half <= 1'b1;
                end
            end else if (w_adv) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            if (w_accept) begin
                r_byte <= w_store;
                r_full <= 1'b1;
                r_half <= 1'b0;
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_data  = r_m_data;
    assign bus.m_valid = r_m_valid;
    assign bus.m_last  = r_m_last;
endmodule
`default_nettype wire

// File: tb/tb_qam16_mapper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_qam16_mapper : directed + random-backpressure bench with symbol model    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_qam16_mapper;
    localparam int LVL = 32;
    localparam int SPF = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    qam16_mapper_if bus();

    qam16_mapper #(.LVL(LVL), .SYM_PER_FRAME(SPF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Gray index -> level index; level = (2*idx-3)*L. Q runs in the opposite direction.
    function automatic logic [15:0] map_sym(input logic [3:0] n);
        int gi, qi, iv, qv;
        gi = int'({n[3], n[3] ^ n[2]});
        qi = 3 - int'({n[1], n[1] ^ n[0]});
        iv = (2 * gi - 3) * LVL;
        qv = (2 * qi - 3) * LVL;
        return {8'(qv), 8'(iv)};
    endfunction

    function automatic logic [3:0] demap(input logic [15:0] d);
        int iv, qv, gi, qi;
        iv = int'($signed(d[7:0]));
        qv = int'($signed(d[15:8]));
        gi = (iv / LVL + 3) / 2;
        qi = 3 - (qv / LVL + 3) / 2;
        return {2'(gi ^ (gi >> 1)), 2'(qi ^ (qi >> 1))};
    endfunction

    typedef struct packed {
        logic [3:0] nib;
        logic       last;
    } exp_t;

    exp_t        q[$];
    int          mcnt, ocnt, cyc, first_cyc, last_cyc, m_bcnt;
    logic [6:0]  m_lfsr;
    logic [63:0] lastmask;
    logic [3:0]  outnib[64];
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    logic [7:0]  stim[1024];
    logic        rec_en = 1'b0;
    logic        rec_rdy[8];
    int          rec_n = 0;

    always @(negedge clk) begin : mon
        exp_t       e;
        logic [7:0] b;
        logic       fb;
        cyc++;
        if (!rst_n) begin
            q.delete();
            mcnt = 0; ocnt = 0; m_bcnt = 0; m_lfsr = 7'h7F;
            lastmask = '0; prev_stall = 1'b0; first_cyc = -1; last_cyc = -1;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.m_valid), 32'd1);
                check("stall_data", 32'(bus.m_data), 32'(prev_data));
                check("stall_last", 32'(bus.m_last), 32'(prev_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_sym: got %0h, expected no symbol", bus.m_data);
                end else begin
                    e = q.pop_front();
                    check("sym_data", 32'(bus.m_data), 32'(map_sym(e.nib)));
                    check("sym_last", 32'(bus.m_last), 32'(e.last));
                    check("demap", 32'(demap(bus.m_data)), 32'(e.nib));
                end
                if (ocnt < 64) begin
                    lastmask[ocnt] = bus.m_last;
                    outnib[ocnt]   = demap(bus.m_data);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                ocnt++;
            end
            if (bus.s_valid && bus.s_ready) begin
                b = bus.s_data;
`ifdef QAM16_MAPPER_SCRAMBLE_EN
                for (int k = 7; k >= 0; k--) begin
                    fb     = m_lfsr[6] ^ m_lfsr[3];
                    b[k]   = b[k] ^ fb;
                    m_lfsr = {m_lfsr[5:0], fb};
                end
                m_bcnt++;
                if (m_bcnt == SPF / 2) begin
                    m_bcnt = 0;
                    m_lfsr = 7'h7F;
                end
`endif
                e.nib = b[7:4]; e.last = (mcnt % SPF == SPF - 1); q.push_back(e); mcnt++;
                e.nib = b[3:0]; e.last = (mcnt % SPF == SPF - 1); q.push_back(e); mcnt++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input int n, input bit rnd);
        int idx   = 0;
        int guard = 0;
        bit acc;
        bus.s_data  = stim[0];
        bus.s_valid = (n > 0);
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            if (rec_en && rec_n < 8) begin
                rec_rdy[rec_n] = bus.s_ready;
                rec_n++;
            end
            @(posedge clk);
            #1;
            guard++;
            if (acc) begin
                idx++;
                if (idx < n) bus.s_data = stim[idx];
            end
            bus.s_valid = (idx < n);
            if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
        end
        bus.s_valid = 1'b0;
        check("send_done", 32'(idx), 32'(n));
    endtask

    task automatic drain();
        int g = 0;
        bus.m_ready = 1'b1;
        while ((q.size() != 0 || bus.m_valid) && g < 200) begin
            tick();
            g++;
        end
        check("drain_queue", 32'(q.size()), 32'd0);
        check("drain_valid", 32'(bus.m_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_data"}, 32'(bus.m_data), 32'h0);
        check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        check({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] exp_nib;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // 0xA5: high nibble A -> I bits 10 = +3L, Q bits 10 = -3L; low nibble 5 -> I=-L, Q=+L.
        stim[0] = 8'hA5;
        send(1, 1'b0);
        @(negedge clk);
        check("a5_gap_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        check("a5_hi_valid", 32'(bus.m_valid), 32'd1);
        check("a5_hi_data", 32'(bus.m_data), 32'hA060);
        @(negedge clk);
        check("a5_lo_data", 32'(bus.m_data), 32'h20E0);
        @(negedge clk);
        check("a5_end_valid", 32'(bus.m_valid), 32'd0);
        drain();

        // All 16 nibbles back-to-back, full rate, frame of 4 symbols.
        do_reset();
        for (int k = 0; k < 8; k++) stim[k] = 8'((2 * k) << 4 | (2 * k + 1));
        rec_en = 1'b1;
        send(8, 1'b0);
        rec_en = 1'b0;
        drain();
        for (int k = 0; k < 6; k++) check("s_ready_pattern", 32'(rec_rdy[k]), 32'((k + 1) % 2));
        check("stream_count", 32'(ocnt), 32'd16);
        check("stream_span", 32'(last_cyc - first_cyc), 32'd15);
        check("stream_lastmask", lastmask[31:0], 32'h0000_8888);
`ifndef QAM16_MAPPER_SCRAMBLE_EN
        for (int k = 0; k < 16; k++) check("loopback_nibble", 32'(outnib[k]), 32'(k));
`endif

        // Random data, 50% backpressure.
        for (int k = 0; k < 1000; k++) stim[k] = 8'($urandom_range(0, 255));
        send(1000, 1'b1);
        drain();

        // Reset with a byte buffered and a symbol stalled at the output.
        do_reset();
        bus.m_ready = 1'b0;
        stim[0] = 8'h3C;
        send(1, 1'b0);
        bus.s_data  = 8'h96;
        bus.s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("held_s_ready", 32'(bus.s_ready), 32'd0);
        end
        check("held_m_data", 32'(bus.m_data), 32'(map_sym(4'h3)));
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) stim[k] = 8'(8'h5A + k);
        send(4, 1'b0);
        drain();
        check("midrst_count", 32'(ocnt), 32'd8);
        check("midrst_lastmask", lastmask[31:0], 32'h0000_0088);

        // Zero bytes across two frames.
        do_reset();
        for (int k = 0; k < 4; k++) stim[k] = 8'h00;
        send(4, 1'b0);
        drain();
`ifdef QAM16_MAPPER_SCRAMBLE_EN
        exp_nib = 32'h0EF2_0EF2;
`else
        exp_nib = 32'h0000_0000;
`endif
        for (int k = 0; k < 8; k++) check("zero_bytes_nibble", 32'(outnib[k]), 32'(exp_nib[31 - 4 * k -: 4]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
